// File: rtl/aeonic_tt_pkg.sv
// Shared types and constant helpers for the aeonic TinyTapeout GPIO adapter.
package aeonic_tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE
  } tt_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int beats(input int gp_width, input int pad_w);
    return (gp_width + pad_w - 1) / pad_w;
  endfunction

endpackage

// File: rtl/aeonic_tt_fifo.sv
// Synchronous first-word-fall-through FIFO; rd_data shows the head whenever !empty.
// Writes while full and reads while empty are ignored; full/empty come from a registered count.
module aeonic_tt_fifo
  import aeonic_tt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aeonic_tt_gpio.sv
// Core GP port <-> TinyTapeout pads: FIFO-buffered words serialised as setup/strobe beat pairs, first beat 2 cycles after pop.
// Strobes while full are dropped and latch overflow; pad_in reaches core_in after 1 cycle, or SYNC_STAGES with AEONIC_TT_SYNC_EN.
module aeonic_tt_gpio
  import aeonic_tt_pkg::*;
#(
  parameter int GP_WIDTH    = 8,
  parameter int PAD_W       = 4,
  parameter int PAD_IN_W    = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [GP_WIDTH-1:0] core_out,
  input  logic                core_out_stb,
  output logic                core_out_full,
  input  logic                ovf_clr,
  output logic                overflow,
  output logic [PAD_W-1:0]    pad_out,
  output logic                pad_stb,
  input  logic [PAD_IN_W-1:0] pad_in,
  output logic [GP_WIDTH-1:0] core_in
);

  localparam int BEATS = beats(GP_WIDTH, PAD_W);
  localparam int BW    = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
  localparam int SW    = BEATS * PAD_W;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef AEONIC_TT_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  localparam int IN_STAGES = SYNC_EN ? SYNC_STAGES : 1;

  tt_state_e           state;
  logic [BW-1:0]       beat;
  logic [SW-1:0]       shreg;
  logic [SW-1:0]       shifted;
  logic [SW-1:0]       head;
  logic [GP_WIDTH-1:0] fifo_rd;
  logic                fifo_empty;
  logic                pop;

  aeonic_tt_fifo #(
    .WIDTH (GP_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (core_out_stb),
    .wr_data (core_out),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .full    (core_out_full),
    .empty   (fifo_empty)
  );

  assign head    = SW'(fifo_rd);
  assign shifted = shreg >> PAD_W;
  assign pop     = !fifo_empty && ((state == IDLE) || (state == STROBE && beat == LAST_BEAT));

  // pad_out is loaded on the edge entering SETUP so the slice is stable for both beat cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      shreg   <= '0;
      pad_out <= '0;
      pad_stb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pad_stb <= 1'b0;
          if (pop) begin
            shreg   <= head;
            pad_out <= head[PAD_W-1:0];
            beat    <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          pad_stb <= 1'b1;
          state   <= STROBE;
        end
        STROBE: begin
          pad_stb <= 1'b0;
          if (beat != LAST_BEAT) begin
            shreg   <= shifted;
            pad_out <= shifted[PAD_W-1:0];
            beat    <= beat + BW'(1);
            state   <= SETUP;
          end else if (pop) begin
            shreg   <= head;
            pad_out <= head[PAD_W-1:0];
            beat    <= '0;
            state   <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          pad_stb <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (core_out_stb && core_out_full) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  if (IN_STAGES > 1) begin : g_sync
    logic [PAD_IN_W-1:0] sync_q [IN_STAGES-1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < IN_STAGES - 1; i++) sync_q[i] <= '0;
        core_in <= '0;
      end else begin
        sync_q[0] <= pad_in;
        for (int i = 1; i < IN_STAGES - 1; i++) sync_q[i] <= sync_q[i-1];
        core_in <= GP_WIDTH'(sync_q[IN_STAGES-2]);
      end
    end
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) core_in <= '0;
      else     core_in <= GP_WIDTH'(pad_in);
    end
  end

endmodule

// File: doc/aeonic_tt_gpio.md
# aeonic_tt_gpio

Parametrised general-purpose I/O adapter between the aeonic core's parallel GP port and the narrow TinyTapeout pad bus. Each strobed output word from the core is buffered in a small FIFO and serialised onto a PAD_W-bit pad bus in setup/strobe beat pairs. Pad inputs are synchronised and zero-extended onto the core's GP input. It replaces the fixed 4-bit, unbuffered gp_out/gp_in pin mapping in the TinyTapeout wrapper.

## Interface
- GP_WIDTH, 8: core GP word width, ≥1.
- PAD_W, 4: pad output bus width, 1..GP_WIDTH.
- PAD_IN_W, 5: pad input width, ≤GP_WIDTH.
- FIFO_DEPTH, 4: output FIFO entries, power of two, ≥2.
- SYNC_STAGES, 2: input synchroniser depth, ≥2; used only with the sync macro.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- core_out  in  GP_WIDTH  word from the core.
- core_out_stb  in  1  one-cycle write strobe.
- core_out_full  out  1  FIFO full.
- ovf_clr  in  1  clears overflow.
- overflow  out  1  sticky flag: a write was dropped.
- pad_out  out  PAD_W  current beat data.
- pad_stb  out  1  high in the strobe cycle of each beat.
- pad_in  in  PAD_IN_W  raw pad inputs.
- core_in  out  GP_WIDTH  {zeros, synchronised pad_in}.

## Operation
- BEATS = ceil(GP_WIDTH/PAD_W).
  - A word is sent least-significant slice first.
  - The last beat is zero-padded above bit GP_WIDTH-1.
- FIFO write: core_out_stb=1 and core_out_full=0 at a rising edge stores core_out.
- core_out_full is derived from the registered occupancy count (count==FIFO_DEPTH).
  - A strobe while full is dropped, even if a pop occurs in the same cycle.
  - A dropped write sets overflow.
- overflow clears on ovf_clr=1.
  - If ovf_clr and a dropped write occur together, set wins.
- The FSM is a registered enum with states IDLE, SETUP, STROBE.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, beat=0, go to SETUP. Otherwise stay in IDLE.
  - SETUP: pad_out = current slice, pad_stb=0. Next state is STROBE.
  - STROBE: pad_out unchanged, pad_stb=1.
    - If beat<BEATS-1: shift right by PAD_W, beat+1, go to SETUP.
    - Else, if the FIFO is non-empty: pop the next word and go to SETUP (no idle gap).
    - Else: go to IDLE.
- In IDLE, pad_out holds its last value and pad_stb=0.
- The beat counter width is clog2(BEATS), minimum 1.
- Simultaneous write and pop with the FIFO not full: both take effect and the count is unchanged.
- Mid-word reset aborts the word, empties the FIFO, and forces pad_stb=0 from the next cycle.

## Timing
- Reset values:
  - pad_out=0, pad_stb=0, core_out_full=0, overflow=0, core_in=0.
  - FIFO empty, state IDLE, beat=0.
- All outputs are registered.
- Latency: strobe in cycle t with FSM idle and FIFO empty:
  - t+1: FSM pops.
  - t+2: first SETUP.
  - t+3: first pad_stb.
- Throughput: one word per 2·BEATS cycles while the FIFO is non-empty.
- External logic samples pad_out on pad_stb; data is stable for the SETUP and STROBE cycles of each beat.
- core_in latency (with the sync macro): SYNC_STAGES cycles.

## Configuration
- AEONIC_TT_SYNC_EN:
  - Defined: pad_in passes through a SYNC_STAGES-deep flop chain before core_in; all stages reset to 0.
  - Undefined: pad_in is registered once into core_in, with 1-cycle latency; SYNC_STAGES is ignored.

## Structure
- Package aeonic_tt_pkg holds:
  - the FSM state typedef (IDLE/SETUP/STROBE);
  - a constant function beats(gp_width, pad_w);
  - a clog2 helper.
- Sub-module aeonic_tt_fifo: a synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, full, empty.
  - Read is first-word-fall-through.
- Serialiser FSM, overflow flag and input synchroniser live in aeonic_tt_gpio.

## Test plan
- Defaults, write 0xA5 once:
  - pad_out/pad_stb over four cycles starting t+2: (5,0),(5,1),(A,0),(A,1).
  - Then IDLE with pad_stb=0.
- Six back-to-back strobes (words 0x01..0x06), DEPTH=4:
  - core_out_full rises during the fifth strobe; 0x06 is dropped; overflow=1.
  - Words 0x01..0x05 are emitted with no idle cycles between them.
- overflow set, then ovf_clr pulsed alone: overflow=0 next cycle. ovf_clr together with a dropped write: overflow stays 1.
- GP_WIDTH=10, PAD_W=4, write 0x3FF: beats F, F, 3, with pad_stb pattern 0,1,0,1,0,1.
- rst asserted in the STROBE cycle of beat 0 with two words queued:
  - Next cycle: pad_stb=0, pad_out=0, core_out_full=0, IDLE.
  - No further beats are emitted.
- With AEONIC_TT_SYNC_EN, pad_in 0x00→0x15: core_in=0x15 exactly SYNC_STAGES cycles later. Without the macro: after 1 cycle.
